// File: rtl/rr_encoder_8_1.sv
// -----------------------------------------------------------------------------
// rr_encoder_8_1
//
// Eight-channel round-robin collecting encoder. It is the inverse of the 1-to-8
// one-hot decoder. When idle, it picks one requesting channel, starting the
// scan at the rotating priority pointer. It then latches that channel's index
// and data word and presents them on a valid/ready output port. The item is
// held until the consumer accepts it.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous, active-high reset
//   req[7:0]   : per-channel request, bit i = channel i
//   din        : channel data, channel i at din[i*DW +: DW]
//   gnt[7:0]   : one-hot, single-cycle pulse marking the captured channel
//   out_valid  : captured item available
//   out_ready  : consumer accepts the item
//   out_sel    : binary index of the captured channel
//   out_data   : captured data word
//   busy       : high while an item is held
// -----------------------------------------------------------------------------
module rr_encoder_8_1 #(
   parameter int DW = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      req,
   input  logic [8*DW-1:0] din,
   output logic [7:0]      gnt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2:0]      out_sel,
   output logic [DW-1:0]   out_data,
   output logic            busy
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t       state, state_next;
   logic [2:0]   ptr;
   logic         found;
   logic [2:0]   pick;
   logic [2:0]   idx;
   logic         capture;
   logic         handshake;
   logic [DW-1:0] pick_data;

   // The scan runs from the farthest offset down to offset 0. The last hit
   // that is written is therefore the channel nearest to ptr, in rotating order.
   always_comb begin
      found = 1'b0;
      pick  = 3'd0;
      idx   = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         idx = ptr + 3'(k);
         if (req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign pick_data = din[int'(pick)*DW +: DW];
   assign capture   = (state == IDLE) && found;
   assign handshake = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found)     state_next = HOLD;
         HOLD:    if (handshake) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // All outputs are registered, so out_ready has no combinational path to any
   // output. out_sel and out_data deliberately keep their values after the
   // handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= 3'd0;
         gnt       <= 8'd0;
         out_valid <= 1'b0;
         out_sel   <= 3'd0;
         out_data  <= '0;
         busy      <= 1'b0;
      end else begin
         gnt <= 8'd0;
         if (capture) begin
            gnt       <= 8'd1 << pick;
            out_sel   <= pick;
            out_data  <= pick_data;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            ptr       <= pick + 3'd1;
         end else if (state == HOLD && handshake) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_encoder_8_1.sv
module tb_rr_encoder_8_1;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] din;
   logic [7:0] gnt;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_sel;
   logic [0:0] out_data;
   logic       busy;

   int errors = 0;
   int checks = 0;

   rr_encoder_8_1 #(.DW(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .din       (din),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_item(input string tag, input int ch, input logic d);
      logic [7:0] oh;
      oh = 8'd1 << ch;
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".sel"},   32'(out_sel),   32'(ch));
      chk({tag, ".data"},  32'(out_data),  32'(d));
      chk({tag, ".gnt"},   32'(gnt),       32'(oh));
      chk({tag, ".busy"},  32'(busy),      32'd1);
   endtask

   initial begin
      rst = 1'b1; req = 8'h00; din = 8'h00; out_ready = 1'b0;
      #1;
      chk("rst.gnt",   32'(gnt),       32'd0);
      chk("rst.valid", 32'(out_valid), 32'd0);
      chk("rst.sel",   32'(out_sel),   32'd0);
      chk("rst.data",  32'(out_data),  32'd0);
      chk("rst.busy",  32'(busy),      32'd0);
      step(); step();
      rst = 1'b0;

      // Single request on channel 2.
      req = 8'b0000_0100; din = 8'b0000_0100; out_ready = 1'b1;
      step();
      chk_item("single", 2, 1'b1);
      req = 8'h00;
      step();
      chk("single.hs.valid", 32'(out_valid), 32'd0);
      chk("single.hs.gnt",   32'(gnt),       32'd0);
      chk("single.hs.busy",  32'(busy),      32'd0);
      chk("single.hs.sel",   32'(out_sel),   32'd2);
      // ptr should be 3: channel 3 wins over channel 0.
      req = 8'b0000_1001; din = 8'h00;
      step();
      chk_item("ptr3", 3, 1'b0);
      req = 8'h00;
      step();
      chk("ptr3.hs.valid", 32'(out_valid), 32'd0);

      // Round robin, starting again from ptr=0.
      rst = 1'b1; #1; rst = 1'b0;
      req = 8'hFF; din = 8'hAA; out_ready = 1'b1;
      for (int n = 0; n < 9; n++) begin
         step();
         chk_item($sformatf("rr%0d", n), n % 8, din[n % 8]);
         step();
         chk($sformatf("rr%0d.idle.valid", n), 32'(out_valid), 32'd0);
         chk($sformatf("rr%0d.idle.gnt", n),   32'(gnt),       32'd0);
      end

      // Wrap and skip: serve channel 5 (ptr -> 6), then {5,0} gives 0 before 5.
      req = 8'b0010_0000; din = 8'b0010_0000;
      step();
      chk_item("wrap.c5", 5, 1'b1);
      req = 8'b0010_0001; din = 8'b0000_0001;
      step();
      chk("wrap.hs1", 32'(out_valid), 32'd0);
      step();
      chk_item("wrap.c0", 0, 1'b1);
      din = 8'b0000_0000;
      step();
      chk("wrap.hs2", 32'(out_valid), 32'd0);
      step();
      chk_item("wrap.c5b", 5, 1'b0);
      step();
      chk("wrap.hs3", 32'(out_valid), 32'd0);

      // Backpressure on channel 3 (ptr=6 scans 6,7,0,1,2,3).
      req = 8'b0000_1000; din = 8'b0000_1000; out_ready = 1'b0;
      step();
      chk_item("bp.cap", 3, 1'b1);
      for (int c = 0; c < 5; c++) begin
         req = (c % 2) ? 8'hF7 : 8'h0F;
         din = (c % 2) ? 8'hFF : 8'h00;
         step();
         chk($sformatf("bp%0d.valid", c), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d.sel", c),   32'(out_sel),   32'd3);
         chk($sformatf("bp%0d.data", c),  32'(out_data),  32'd1);
         chk($sformatf("bp%0d.gnt", c),   32'(gnt),       32'd0);
      end
      req = 8'hF0; din = 8'h10; out_ready = 1'b1;
      step();
      chk("bp.hs.valid", 32'(out_valid), 32'd0);
      chk("bp.hs.sel",   32'(out_sel),   32'd3);
      step();
      chk_item("bp.next", 4, 1'b1);

      // Asynchronous reset while an item is held.
      out_ready = 1'b0; req = 8'h00;
      #2 rst = 1'b1;
      #1;
      chk("arst.valid", 32'(out_valid), 32'd0);
      chk("arst.gnt",   32'(gnt),       32'd0);
      chk("arst.sel",   32'(out_sel),   32'd0);
      chk("arst.data",  32'(out_data),  32'd0);
      chk("arst.busy",  32'(busy),      32'd0);
      step();
      rst = 1'b0;
      step();
      chk("arst.nogrant", 32'(gnt),       32'd0);
      chk("arst.novalid", 32'(out_valid), 32'd0);
      req = 8'h80; din = 8'h80;
      step();
      chk_item("arst.c7", 7, 1'b1);
      req = 8'h00; out_ready = 1'b1;
      step();
      chk("arst.hs", 32'(out_valid), 32'd0);

      // Idle for 20 cycles; ptr (now 0) must not move.
      out_ready = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         chk($sformatf("idle%0d.gnt", c),   32'(gnt),       32'd0);
         chk($sformatf("idle%0d.valid", c), 32'(out_valid), 32'd0);
         chk($sformatf("idle%0d.busy", c),  32'(busy),      32'd0);
      end
      req = 8'hFF; din = 8'h01;
      step();
      chk_item("idle.after", 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_encoder_8_1.md
Name: rr_encoder_8_1

Overview:
- 8-to-1 collecting encoder: the inverse of the team's 1-to-8 one-hot demux/decoder.
- Eight requesters raise `req` lines, each with a data word. The block picks one channel by round-robin, encodes its 3-bit index, and presents index plus data on a valid/ready output port.
- Sits between eight producer channels and a single downstream consumer. The consumer can feed `out_sel` straight back into the 1-to-8 decoder to address a reply.

Parameters:
- DW, 1, data width per channel.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous, active-high reset.
- req, input, 8, per-channel request. Bit i belongs to channel i.
- din, input, 8*DW, channel data. Channel i occupies din[i*DW +: DW].
- gnt, output, 8, one-hot grant pulse. Asserted for one cycle when channel i is captured.
- out_valid, output, 1, captured item available.
- out_ready, input, 1, consumer accepts the item.
- out_sel, output, 3, binary index of the captured channel.
- out_data, output, DW, captured data.
- busy, output, 1, high while in HOLD.

Behaviour:
- Reset (async, rst=1): state=IDLE, ptr=0, gnt=0, out_valid=0, out_sel=0, out_data=0, busy=0. Reset overrides everything, including a pending item in HOLD; that item is dropped and no gnt is re-issued.
- ptr: 3-bit register holding the highest-priority channel for the next arbitration.
- FSM state IDLE:
  - req==0: stay in IDLE; all outputs hold their idle values.
  - req!=0: select the first set bit scanning i = ptr, ptr+1, …, ptr+7 (mod 8).
  - On that clock edge: out_sel<=i, out_data<=din[i], gnt<=one-hot(i) for exactly one cycle, out_valid<=1, busy<=1, ptr<=(i+1) mod 8 (7 wraps to 0), go to HOLD.
- FSM state HOLD:
  - out_sel and out_data are frozen. req and din are ignored.
  - gnt returns to 0 on the cycle after capture.
  - out_valid && out_ready at a rising edge is the handshake. It sets out_valid<=0, busy<=0, next state IDLE.
  - out_sel and out_data keep their last values after the handshake and are not cleared.
- Latency: gnt and out_valid rise on the same edge, one cycle after req is sampled in IDLE.
- Throughput: at most one item per 2 cycles, because every handshake passes through one IDLE cycle.
- Requester contract:
  - Hold req and din stable until its gnt bit is seen.
  - Drop req on the cycle after gnt, or keep it high to re-request.
  - A channel that keeps req high is re-served only after every other requesting channel has had a turn.
- out_ready while out_valid=0 has no effect.
- Multiple simultaneous requests: exactly one channel is granted per capture; gnt is never multi-hot.
- Combinational out_ready→out_valid paths are forbidden; all outputs come from registers.

Test Plan:
- Single request: reset; req=8'b0000_0100, DW=1, din[2]=1 → next edge: gnt=8'b0000_0100 for 1 cycle, out_valid=1, out_sel=3'd2, out_data=1. With out_ready=1, out_valid drops after 1 cycle; ptr=3.
- Round-robin: req=8'hFF held, out_ready=1 → out_sel sequence 0,1,2,…,7,0, one item every 2 cycles; each gnt one-hot matches out_sel.
- Wrap and skip: ptr=6 (reached by serving channel 5), req=8'b0010_0001 → channel 0 granted first (scan 6,7,0), then channel 5.
- Backpressure: capture channel 3 with out_ready=0 for 5 cycles while din and req change → out_valid, out_sel=3 and out_data stay stable; no second gnt; handshake on cycle 6, then the next capture.
- Reset mid-operation: rst=1 asynchronously while in HOLD with out_valid=1 → out_valid, gnt, out_sel and out_data go to 0 immediately. After release with req=8'h80 → channel 7 is granted (ptr was reset to 0 and scans to 7).
- Idle: req=0 for 20 cycles → gnt=0, out_valid=0, busy=0 throughout; ptr unchanged.
